// File: rtl/mat_mult_seq.sv
// Sequential NxN unsigned matrix multiplier sharing one multiply-accumulate unit.
// Optional macro MAT_MULT_SAT_EN: saturate overflowing elements instead of wrapping.
module mat_mult_seq #(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [N*N*DW-1:0]   a,
    input  logic [N*N*DW-1:0]   b,
    output logic [N*N*DW-1:0]   c,
    output logic                busy,
    output logic                done,
    output logic                high
);
    localparam int IW = $clog2(N);
    localparam int EW = $clog2(N*N);
    localparam int AW = 2*DW + $clog2(N);
    localparam int NE = N*N;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [DW-1:0]       a_q   [NE];
    logic [DW-1:0]       b_q   [NE];
    logic [DW-1:0]       buf_q [NE];
    logic                sticky_q;
    logic                high_q;
    logic [NE*DW-1:0]    c_q;
    logic [NE*DW-1:0]    c_next;

    logic [EW-1:0]       a_addr, b_addr, w_addr;
    logic [2*DW-1:0]     prod;
    logic                elem_ovf;
    logic [DW-1:0]       elem_val;
    logic                last_i, last_j, last_k;

    assign a_addr   = EW'(i_q) * EW'(N) + EW'(k_q);
    assign b_addr   = EW'(k_q) * EW'(N) + EW'(j_q);
    assign w_addr   = EW'(i_q) * EW'(N) + EW'(j_q);
    assign prod     = (2*DW)'(a_q[a_addr]) * (2*DW)'(b_q[b_addr]);
    assign last_i   = (i_q == IW'(N-1));
    assign last_j   = (j_q == IW'(N-1));
    assign last_k   = (k_q == IW'(N-1));
    assign elem_ovf = |acc_q[AW-1:DW];

`ifdef MAT_MULT_SAT_EN
    assign elem_val = elem_ovf ? {DW{1'b1}} : acc_q[DW-1:0];
`else
    assign elem_val = acc_q[DW-1:0];
`endif

    // Final result image: buffer contents with the element being written merged in.
    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_cnext
            assign c_next[gi*DW +: DW] = (w_addr == EW'(gi)) ? elem_val : buf_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_MAC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_MAC: begin
                acc_d = acc_q + AW'(prod);
                k_d   = k_q + 1'b1;
                if (last_k) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                acc_d   = '0;
                k_d     = '0;
                state_d = S_MAC;
                if (last_j) begin
                    j_d = '0;
                    if (last_i) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            high_q   <= 1'b0;
            c_q      <= '0;
            for (int e = 0; e < NE; e++) begin
                a_q[e]   <= '0;
                b_q[e]   <= '0;
                buf_q[e] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            if (state_q == S_IDLE && enable) begin
                sticky_q <= 1'b0;
                for (int e = 0; e < NE; e++) begin
                    a_q[e] <= a[e*DW +: DW];
                    b_q[e] <= b[e*DW +: DW];
                end
            end
            if (state_q == S_WRITE) begin
                buf_q[w_addr] <= elem_val;
                sticky_q      <= sticky_q | elem_ovf;
                if (last_i && last_j) begin
                    c_q    <= c_next;
                    high_q <= sticky_q | elem_ovf;
                end
            end
        end
    end

    assign c    = c_q;
    assign high = high_q;
    assign busy = (state_q == S_MAC) || (state_q == S_WRITE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed self-checking bench for mat_mult_seq (3x3/8-bit and 2x2/4-bit instances).
module tb_mat_mult_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable, enable2;
    logic [71:0] a_s, b_s;
    logic [71:0] c_s;
    logic        busy, done, high;
    logic [15:0] a2, b2;
    logic [15:0] c2;
    logic        busy2, done2, high2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mat_mult_seq #(.N(3), .DW(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .a(a_s), .b(b_s),
        .c(c_s), .busy(busy), .done(done), .high(high)
    );

    mat_mult_seq #(.N(2), .DW(4)) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .a(a2), .b(b2),
        .c(c2), .busy(busy2), .done(done2), .high(high2)
    );

    function automatic logic [71:0] mk_ident(input logic [7:0] d);
        logic [71:0] m = '0;
        for (int i = 0; i < 3; i++) m[(i*3+i)*8 +: 8] = d;
        return m;
    endfunction

    function automatic logic [71:0] mk_const(input logic [7:0] v);
        logic [71:0] m;
        for (int e = 0; e < 9; e++) m[e*8 +: 8] = v;
        return m;
    endfunction

    function automatic logic [71:0] mk_seq();
        logic [71:0] m;
        for (int e = 0; e < 9; e++) m[e*8 +: 8] = 8'(e + 1);
        return m;
    endfunction

    // Accept an operation at the next edge (cycle 0), then wait for done.
    task automatic run_op(input logic [71:0] av, input logic [71:0] bv,
                          output int lat, output bit busy_ok);
        a_s = av; b_s = bv; enable = 1'b1;
        @(posedge clk); #1;
        enable  = 1'b0;
        busy_ok = (busy === 1'b1);
        lat     = 999;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = cyc;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; enable2 = 1'b0;
        a_s = '0; b_s = '0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (c_s !== 72'h0 || high !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: c=%h high=%b busy=%b done=%b required c=0 high=0 busy=0 done=0", c_s, high, busy, done);
        end
        // rst and enable together: reset must win
        enable = 1'b1; a_s = mk_const(8'd1); b_s = mk_const(8'd1);
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_wins: busy=%b required 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_identity();
        int lat; bit bok;
        run_op(mk_ident(8'd1), mk_seq(), lat, bok);
        checks++;
        if (lat !== 36) begin failures++; $display("FAIL identity_latency: got %0d required 36", lat); end
        checks++;
        if (c_s !== mk_seq()) begin failures++; $display("FAIL identity_c: got %h required %h", c_s, mk_seq()); end
        checks++;
        if (high !== 1'b0) begin failures++; $display("FAIL identity_high: got %b required 0", high); end
        checks++;
        if (!bok) begin failures++; $display("FAIL identity_busy: busy not high throughout (got 0 required 1)"); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL identity_done_pulse: done=%b one cycle later, required 0", done); end
        $display("test_identity lat=%0d c=%h high=%b", lat, c_s, high);
    endtask

    task automatic test_overflow();
        int lat; bit bok;
        logic [71:0] exp_c;
`ifdef MAT_MULT_SAT_EN
        exp_c = mk_const(8'hFF);
`else
        exp_c = mk_const(8'h03);
`endif
        run_op(mk_const(8'hFF), mk_const(8'hFF), lat, bok);
        checks++;
        if (c_s !== exp_c) begin failures++; $display("FAIL overflow_c: got %h required %h", c_s, exp_c); end
        checks++;
        if (high !== 1'b1) begin failures++; $display("FAIL overflow_high: got %b required 1", high); end
        @(posedge clk); #1;
        $display("test_overflow lat=%0d c=%h high=%b", lat, c_s, high);
    endtask

    task automatic test_boundary();
        int lat; bit bok;
        run_op(mk_ident(8'hFF), mk_ident(8'd1), lat, bok);
        checks++;
        if (c_s !== mk_ident(8'hFF)) begin failures++; $display("FAIL boundary_c: got %h required %h", c_s, mk_ident(8'hFF)); end
        checks++;
        if (high !== 1'b0) begin failures++; $display("FAIL boundary_high: got %b required 0", high); end
        @(posedge clk); #1;
        $display("test_boundary c=%h high=%b", c_s, high);
    endtask

    task automatic test_capture_ignore();
        int done_cnt = 0;
        int done_at  = -1;
        a_s = mk_const(8'd2); b_s = mk_const(8'd3); enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            if (cyc == 5) begin a_s = mk_const(8'd7); enable = 1'b1; end
            @(posedge clk); #1;
            if (cyc == 5) enable = 1'b0;
            if (done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = cyc; end
            if (cyc > 37 && busy !== 1'b0) begin
                done_cnt = done_cnt + 100;
                break;
            end
        end
        checks++;
        if (done_at !== 36) begin failures++; $display("FAIL capture_latency: done at %0d required 36", done_at); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL capture_single_op: done/second-op count %0d required 1", done_cnt); end
        checks++;
        if (c_s !== mk_const(8'h12)) begin failures++; $display("FAIL capture_c: got %h required %h", c_s, mk_const(8'h12)); end
        $display("test_capture_ignore done_at=%0d c=%h", done_at, c_s);
    endtask

    task automatic test_reset_midop();
        int lat; bit bok;
        int dcnt = 0;
        a_s = mk_const(8'd1); b_s = mk_const(8'd1); enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || c_s !== 72'h0 || done !== 1'b0 || high !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: busy=%b c=%h done=%b high=%b required busy=0 c=0 done=0 high=0", busy, c_s, done, high);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt !== 0) begin failures++; $display("FAIL midop_no_done: activity cycles %0d required 0", dcnt); end
        run_op(mk_ident(8'd1), mk_seq(), lat, bok);
        checks++;
        if (c_s !== mk_seq() || lat !== 36) begin
            failures++;
            $display("FAIL midop_rerun: c=%h lat=%0d required c=%h lat=36", c_s, lat, mk_seq());
        end
        @(posedge clk); #1;
        $display("test_reset_midop rerun c=%h lat=%0d", c_s, lat);
    endtask

    task automatic test_back_to_back();
        int d1 = -1;
        int d2 = -1;
        logic b37 = 1'bx;
        logic b38 = 1'bx;
        a_s = mk_ident(8'd1); b_s = mk_seq(); enable = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 37) b37 = busy;
            if (cyc == 38) b38 = busy;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc;
            end
        end
        enable = 1'b0;
        checks++;
        if (d1 !== 36 || d2 !== 74) begin failures++; $display("FAIL b2b_done: done at %0d,%0d required 36,74", d1, d2); end
        checks++;
        if (b37 !== 1'b0 || b38 !== 1'b1) begin failures++; $display("FAIL b2b_busy: busy@37=%b busy@38=%b required 0,1", b37, b38); end
        repeat (80) @(posedge clk);
        #1;
        $display("test_back_to_back done at %0d and %0d", d1, d2);
    endtask

    task automatic test_param_sweep();
        int lat = 999;
        logic [15:0] exp_c;
`ifdef MAT_MULT_SAT_EN
        exp_c = 16'hFFFF;
`else
        exp_c = 16'h2222;
`endif
        a2 = 16'hFFFF; b2 = 16'hFFFF; enable2 = 1'b1;
        @(posedge clk); #1;
        enable2 = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk); #1;
            if (done2 === 1'b1) begin lat = cyc; break; end
        end
        checks++;
        if (lat !== 12) begin failures++; $display("FAIL sweep_latency: got %0d required 12", lat); end
        checks++;
        if (c2 !== exp_c) begin failures++; $display("FAIL sweep_c: got %h required %h", c2, exp_c); end
        checks++;
        if (high2 !== 1'b1) begin failures++; $display("FAIL sweep_high: got %b required 1", high2); end
        $display("test_param_sweep lat=%0d c=%h high=%b", lat, c2, high2);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_overflow();
        test_boundary();
        test_capture_ignore();
        test_reset_midop();
        test_back_to_back();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mat_mult_seq.md
# mat_mult_seq

Parametrised sequential N×N unsigned matrix multiplier: computes C = A·B with a single shared multiply-accumulate unit, one product term per cycle. It generalises the fixed 3×3, 8-bit multiplier to arbitrary dimension and element width. It adds an explicit start/busy/done handshake, operand capture and a per-operation overflow flag. It sits beside the convolution datapath as its matrix-product engine.

## Interface
- `N`, default 3: matrix dimension (N ≥ 2).
- `DW`, default 8: element width in bits, unsigned.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: start request; sampled only in IDLE.
- `a` input N*N*DW: matrix A, row-major; element (i,j) at `[(i*N+j)*DW +: DW]`.
- `b` input N*N*DW: matrix B, same packing as `a`.
- `c` output N*N*DW: result matrix, same packing; registered.
- `busy` output 1: operation in progress (states MAC, WRITE).
- `done` output 1: one-cycle pulse; `c` and `high` valid and updated.
- `high` output 1: at least one element of the last result exceeded 2^DW−1; registered.

## Operation
- FSM states: IDLE, MAC, WRITE, DONE.
- IDLE: `enable`=1 at an edge captures `a` and `b` into internal operand registers, clears indices i, j, k and the accumulator, and moves to MAC. `enable`=0 stays in IDLE.
- MAC: each edge does acc += A[i][k]·B[k][j] and increments k. After the k=N−1 term, the FSM moves to WRITE.
- WRITE: stores the element into the internal result buffer, ORs its overflow into an internal sticky flag, clears acc and k, and advances j, then i.
  - If the element was not the last one, return to MAC.
  - After element (N−1,N−1), go to DONE. On that same edge, load `c` from the buffer (including the final element) and `high` from the sticky flag.
- DONE: `done`=1 for exactly one cycle, then unconditionally to IDLE.
- Accumulator width is 2*DW + clog2(N). There is no internal overflow.
- An element overflows when acc > 2^DW−1. The stored value then depends on the configuration (see below).
- `enable` outside IDLE, including during DONE, is ignored and is not queued.
- `a`/`b` may change freely after capture; the result depends only on the captured values.
- `c` and `high` hold their values between `done` pulses. Intermediate elements are never visible on `c`.
- Reset at any time, including mid-operation:
  - next state IDLE;
  - acc, indices, buffer and sticky flag cleared;
  - `c`=0, `high`=0, `busy`=0, `done`=0;
  - no `done` for the aborted operation.
- Simultaneous `rst` and `enable`: reset wins; the operation does not start.

## Timing
- Reset values: `c`=0, `high`=0, `busy`=0, `done`=0.
- Cycle 0 is the edge that accepts `enable`; `busy`=1 from cycle 0.
- Each element takes N MAC edges plus 1 WRITE edge.
- `done`=1 in the cycle following edge N²(N+1), i.e. 36 for N=3, DW=8. In that same cycle `busy`=0.
- The earliest next accept is the edge after the DONE cycle, giving a minimum operation period of N²(N+1)+2 edges.
- Holding `enable` at 1 continuously runs back-to-back operations at that period.

## Configuration
- `MAT_MULT_SAT_EN` defined: an overflowing element is stored as saturated 2^DW−1 (all ones).
- Undefined: an overflowing element is stored as `acc[DW-1:0]` (wrap).
- `high` behaves identically in both builds.

## Test plan
- Identity (N=3, DW=8): A = I and B = {1..9} row-major. Required: `c` = B, `high`=0, `done` pulse exactly 36 edges after accept, `busy` high throughout.
- Overflow: A and B all 0xFF; each element is 195075. Required: every element 0x03 without `MAT_MULT_SAT_EN`, 0xFF with it; `high`=1 in both builds.
- Boundary: A = diag(0xFF), B = I. Required: diagonal 0xFF, off-diagonal 0, `high`=0 (exactly 2^DW−1 is not overflow).
- Capture/ignore: A and B all 2 and 3. Change `a` and pulse `enable` at cycle 5. Required: all elements 0x12, a single `done` at cycle 36, no second operation.
- Reset mid-op: assert `rst` at cycle 10 of a run. Required: next cycle `busy`=0 and `c`=0, with no `done`. A following run with A=I, B={1..9} returns the correct `c`.
- Parameter sweep: N=2, DW=4 with A=[[15,15],[15,15]] and B=A. Required: elements 450 → wrap 0x2 or saturate 0xF, `high`=1, `done` after 12 edges.
